// File: rtl/maj_net_eval.sv
// Sequential evaluator for a programmable chain of 3-input majority gates, one gate per cycle.
// Latency: out_valid rises N_GATES+1 cycles after the accept cycle; one vector per N_GATES+2 cycles.
// Backpressure: in_ready is low outside IDLE; result and out_y are held in DONE until out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset (also clears the program)
//   cfg_we/addr/data      program one gate: data = {c, b, a}, each field {inv, sel}
//   cfg_err               one-cycle pulse when a write is dropped (busy or bad address)
//   in_valid/ready/x      input vector handshake
//   out_valid/ready/y     result handshake; out_fwd_err flags an illegal operand read
module maj_net_eval #(
  parameter int N_IN    = 7,
  parameter int N_GATES = 6,
  localparam int SEL_W  = $clog2(N_IN + N_GATES + 1),
  localparam int CFG_W  = 3 * (SEL_W + 1),
  localparam int AW     = (N_GATES > 1) ? $clog2(N_GATES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_fwd_err
);

  localparam int FW = SEL_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CFG_W-1:0]  r_cfg [N_GATES];
  logic [N_IN-1:0]   r_x;
  logic [N_GATES-1:0] r_g;
  logic [AW-1:0]     r_k;
  logic              r_fwd_err;
  logic              r_cfg_err;

  logic              w_accept;
  logic              w_cfg_ok;
  logic              w_last;
  logic [CFG_W-1:0]  w_cfg_k;
  logic [1:0]        w_op_a, w_op_b, w_op_c;
  logic              w_gate;
  logic              w_gate_err;

  // Resolve one operand field: returns {illegal_read, value_after_inversion}.
  // Gate results are only legal when they come from an earlier gate (j < k);
  // anything else reads as 0 before the inversion bit is applied.
  function automatic logic [1:0] f_operand(
    input logic [FW-1:0]      fld,
    input logic [N_IN-1:0]    x,
    input logic [N_GATES-1:0] g,
    input logic [AW-1:0]      k
  );
    logic raw;
    logic err;
    int   sel;
    raw = 1'b0;
    err = 1'b0;
    sel = int'(fld[SEL_W-1:0]);
    for (int i = 0; i < N_IN; i++) begin
      if (sel == i + 1) raw = x[i];
    end
    for (int j = 0; j < N_GATES; j++) begin
      if (sel == N_IN + 1 + j) begin
        if (j < int'(k)) raw = g[j];
        else             err = 1'b1;
      end
    end
    if (sel > N_IN + N_GATES) err = 1'b1;
    return {err, raw ^ fld[SEL_W]};
  endfunction

  assign w_cfg_k    = r_cfg[r_k];
  assign w_op_a     = f_operand(w_cfg_k[0 +: FW],      r_x, r_g, r_k);
  assign w_op_b     = f_operand(w_cfg_k[FW +: FW],     r_x, r_g, r_k);
  assign w_op_c     = f_operand(w_cfg_k[2*FW +: FW],   r_x, r_g, r_k);
  assign w_gate     = (w_op_a[0] & w_op_b[0]) | (w_op_a[0] & w_op_c[0]) | (w_op_b[0] & w_op_c[0]);
  assign w_gate_err = w_op_a[1] | w_op_b[1] | w_op_c[1];

  assign w_last   = (r_k == AW'(N_GATES - 1));
  assign w_accept = in_valid && (r_state == S_IDLE);
  // Program is frozen outside IDLE so an evaluation always sees one consistent netlist.
  assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && (int'(cfg_addr) < N_GATES);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_g       <= '0;
      r_k       <= '0;
      r_fwd_err <= 1'b0;
      r_cfg_err <= 1'b0;
      for (int i = 0; i < N_GATES; i++) r_cfg[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_ok) r_cfg[cfg_addr] <= cfg_data;
      if (w_accept) begin
        r_x       <= in_x;
        r_g       <= '0;
        r_fwd_err <= 1'b0;
        r_k       <= '0;
      end
      if (r_state == S_EVAL) begin
        r_g[r_k]  <= w_gate;
        r_fwd_err <= r_fwd_err | w_gate_err;
        // Wrap to 0 after the last gate so the config read index stays in range.
        r_k       <= w_last ? '0 : r_k + AW'(1);
      end
    end
  end

  assign out_y       = r_g[N_GATES-1];
  assign out_fwd_err = r_fwd_err;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_maj_net_eval.sv
module tb_maj_net_eval;
  localparam int N_IN    = 7;
  localparam int N_GATES = 6;
  localparam int CFG_W   = 15;
  localparam int AW      = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_fwd_err;

  always #5 clk = ~clk;

  maj_net_eval #(.N_IN(N_IN), .N_GATES(N_GATES)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_fwd_err(out_fwd_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed { logic y; logic err; } res_t;
  res_t sb[$];

  typedef struct { logic [N_IN-1:0] x; logic y; logic err; } vec_t;
  vec_t tbl[10];

  function automatic logic [4:0] fld(input logic inv, input logic [3:0] sel);
    return {inv, sel};
  endfunction

  function automatic logic [CFG_W-1:0] cfg3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [CFG_W-1:0] d, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_after_write", cfg_err, exp_err);
  endtask

  task automatic load_shared();
    cfg_write(0, cfg3(fld(0, 3), fld(0, 4), fld(0, 6)),  1'b0);
    cfg_write(1, cfg3(fld(0, 3), fld(0, 4), fld(0, 5)),  1'b0);
    cfg_write(2, cfg3(fld(0, 2), fld(0, 5), fld(0, 6)),  1'b0);
    cfg_write(3, cfg3(fld(0, 1), fld(0, 9), fld(0, 10)), 1'b0);
    cfg_write(4, cfg3(fld(0, 7), fld(0, 8), fld(0, 11)), 1'b0);
    cfg_write(5, cfg3(fld(0, 1), fld(0, 2), fld(0, 12)), 1'b0);
  endtask

  task automatic accept(input logic [N_IN-1:0] x, input res_t e);
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1; in_x = x;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("in_ready_in_eval", in_ready, 1'b0);
  endtask

  // Wait for the result; pop and compare; latency counted from the accept cycle.
  task automatic collect(input string nm);
    int   cyc;
    res_t e;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: out_valid never rose within %0d cycles", nm, cyc);
      return;
    end
    chk({nm, "_latency"}, cyc, N_GATES + 1);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_sb: output with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_y"}, out_y, e.y);
      chk({nm, "_fwd_err"}, out_fwd_err, e.err);
    end
  endtask

  task automatic run_vec(input logic [N_IN-1:0] x, input logic ey, input logic eerr, input string nm);
    accept(x, '{y: ey, err: eerr});
    collect(nm);
    tick();
    chk({nm, "_in_ready_after"}, in_ready, 1'b1);
    chk({nm, "_out_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b1;

    tbl[0] = '{x: 7'h7F, y: 1'b1, err: 1'b0};
    tbl[1] = '{x: 7'h00, y: 1'b0, err: 1'b0};
    tbl[2] = '{x: 7'h03, y: 1'b1, err: 1'b0};
    tbl[3] = '{x: 7'h01, y: 1'b0, err: 1'b0};
    tbl[4] = '{x: 7'h7C, y: 1'b0, err: 1'b0};
    tbl[5] = '{x: 7'h7D, y: 1'b1, err: 1'b0};
    tbl[6] = '{x: 7'h7E, y: 1'b1, err: 1'b0};
    tbl[7] = '{x: 7'h02, y: 1'b0, err: 1'b0};
    tbl[8] = '{x: 7'h1D, y: 1'b1, err: 1'b0};
    tbl[9] = '{x: 7'h09, y: 1'b0, err: 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_y", out_y, 1'b0);
    chk("reset_fwd_err", out_fwd_err, 1'b0);
    chk("reset_cfg_err", cfg_err, 1'b0);

    // Shared program; table covers the all-ones/all-zeros and x0/x1 dominated cases.
    load_shared();
    for (int i = 0; i < 10; i++) run_vec(tbl[i].x, tbl[i].y, tbl[i].err, "tbl");

    // Backpressure in DONE with a config write attempted (addr 5 -> const 0 would force y=0).
    out_ready = 1'b0;
    accept(7'h1D, '{y: 1'b1, err: 1'b0});
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      cfg_we = (i == 1); cfg_addr = 3'd5; cfg_data = '0;
      tick();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_y", out_y, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_cfg_err", cfg_err, (i == 1) ? 32'd1 : 32'd0);
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", in_ready, 1'b1);
    run_vec(7'h7F, 1'b1, 1'b0, "bp_mem_kept");

    // Self reference on gate 0 (inverted) and g5 = MAJ(g0,g0,g0).
    cfg_write(0, cfg3(fld(1, 8), fld(1, 0), fld(1, 0)), 1'b0);
    cfg_write(5, cfg3(fld(0, 8), fld(0, 8), fld(0, 8)), 1'b0);
    run_vec(7'h00, 1'b1, 1'b1, "selfref");
    // Out-of-range selector: a reads 0, b=c=g0=1 -> y=1 with error.
    cfg_write(5, cfg3(fld(0, 15), fld(0, 8), fld(0, 8)), 1'b0);
    run_vec(7'h00, 1'b1, 1'b1, "oor_sel");
    // Restore the program; error flag must not carry into the next evaluation.
    load_shared();
    run_vec(7'h7F, 1'b1, 1'b0, "err_cleared");

    // Reset mid-EVAL at k=3: result dropped, config cleared.
    in_valid = 1'b1; in_x = 7'h7F;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_fwd_err", out_fwd_err, 1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (out_valid) seen++;
      end
      chk("rst_mid_no_result", seen, 0);
    end
    run_vec(7'h7F, 1'b0, 1'b0, "cleared_7f");
    run_vec(7'h1D, 1'b0, 1'b0, "cleared_1d");

    // Bad address: one-cycle cfg_err pulse, nothing written.
    cfg_write(3'd6, cfg3(fld(1, 0), fld(1, 0), fld(1, 0)), 1'b1);
    tick();
    chk("bad_addr_pulse_end", cfg_err, 1'b0);
    cfg_write(3'd7, cfg3(fld(1, 0), fld(1, 0), fld(1, 0)), 1'b1);
    run_vec(7'h7F, 1'b0, 1'b0, "bad_addr_nochange");

    // Simultaneous write and accept: g5 becomes constant 1 for this very vector.
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = cfg3(fld(1, 0), fld(1, 0), fld(1, 0));
    in_valid = 1'b1; in_x = 7'h00;
    sb.push_back('{y: 1'b1, err: 1'b0});
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("simul_cfg_err", cfg_err, 1'b0);
    collect("simul");
    tick();
    chk("simul_in_ready_after", in_ready, 1'b1);

    chk("sb_empty_at_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maj_net_eval.md
Name: maj_net_eval

Overview:
- Programmable, sequential evaluator for single-output Boolean functions built as a chain of 3-input majority gates (MAJ) over N_IN primary inputs.
- Generalises the team's fixed majority-network classification netlists: gate count, input count and wiring are loaded at run time through a config port.
- Input vectors are evaluated one gate per cycle behind valid/ready handshakes.
- Sits between the vector stimulus source and the classification result collector.

Parameters:
- N_IN, 7, number of primary inputs x[N_IN-1:0].
- N_GATES, 6, number of MAJ gates in the chain; the last gate drives the result.
- SEL_W, $clog2(N_IN+N_GATES+1), operand selector width (derived, not overridden).
- CFG_W, 3*(SEL_W+1), config word width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  $clog2(N_GATES)  gate index to program
- cfg_data  in  CFG_W  three operand fields {inv,sel}; operand a in LSBs
- cfg_err  out  1  one-cycle pulse: write rejected
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_x  in  N_IN  input vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  1  function value (last gate output)
- out_fwd_err  out  1  a forward/out-of-range reference was read during this evaluation

Behaviour:
- Operand encoding:
  - sel=0: constant 0.
  - sel=1..N_IN: x[sel-1].
  - sel=N_IN+1+k: result of gate k.
  - inv=1 complements the operand, so sel=0 with inv=1 gives constant 1.
- Gate k = MAJ(a,b,c) = ab | ac | bc on the post-inversion operands.
- Illegal references:
  - sel referring to gate j>=k, or sel>N_IN+N_GATES, reads 0 before inversion.
  - Such a read sets the sticky out_fwd_err for the current evaluation.
- Config memory (N_GATES x CFG_W):
  - Reset clears all entries to 0, so every gate evaluates to 0.
  - A write is accepted only in IDLE and only if cfg_addr<N_GATES.
  - Otherwise the write is dropped and cfg_err pulses high the next cycle.
- FSM states IDLE, EVAL, DONE:
  - IDLE: in_ready=1. in_valid&in_ready latches in_x, clears gate results and fwd_err, k<=0, goes to EVAL.
  - EVAL: in_ready=0. Each cycle computes gate k, stores it, k<=k+1. After gate N_GATES-1 is stored, goes to DONE.
  - DONE: out_valid=1; out_y = gate N_GATES-1 and is held stable while out_valid&!out_ready. out_valid&out_ready returns to IDLE.
- Latency: the accept edge plus N_GATES EVAL cycles, so out_valid first asserts N_GATES+1 cycles after the accepting edge.
- Throughput: one vector per N_GATES+2 cycles with out_ready held high. No overlap; in_ready is low in EVAL and DONE.
- Config writes in EVAL or DONE are rejected with cfg_err, so the program is stable during an evaluation.
- Simultaneous cfg_we and in_valid in IDLE: both take effect. The write lands first and is used by the accepted vector.
- Reset values: in_ready=1 (after reset), out_valid=0, out_y=0, out_fwd_err=0, cfg_err=0, FSM=IDLE.
- rst asserted mid-EVAL or in DONE aborts the evaluation, drops any pending result and clears the config memory.
- out_fwd_err is valid only with out_valid.

Test Plan:
- Shared program, used by scenarios 1–4:
  - g0=MAJ(x2,x3,x5) (sel 3,4,6)
  - g1=MAJ(x2,x3,x4) (sel 3,4,5)
  - g2=MAJ(x1,x4,x5) (sel 2,5,6)
  - g3=MAJ(x0,g1,g2) (sel 1,9,10)
  - g4=MAJ(x6,g0,g3) (sel 7,8,11)
  - g5=MAJ(x0,x1,g4) (sel 1,2,12)
- Scenario 1: load the program, apply in_x=7'h7F -> out_y=1; apply in_x=7'h00 -> out_y=0. Each result arrives 7 cycles after accept, with out_fwd_err=0.
- Scenario 2: same program, in_x=7'b0000011 (x0=x1=1) -> out_y=1; in_x=7'b0000001 -> out_y=0.
- Scenario 3: backpressure. Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_y stable, in_ready=0. Issue cfg_we during that window -> cfg_err pulses and the memory is unchanged.
- Scenario 4: program gate 0 with sel=N_IN+1 (self reference) and inv=1 on operand a, b=c=sel 0 inv 1 -> operand a reads 0, then inverts to 1. Expect g0=1 and out_fwd_err=1.
- Scenario 5: pulse rst during EVAL (k=3) -> next cycle out_valid=0, in_ready=1. A new vector then evaluates to 0, since config is cleared.
- Scenario 6: cfg_addr=N_GATES write -> cfg_err=1, no memory change. Simultaneous valid cfg_we and in_valid in IDLE -> the result reflects the new entry.
